// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline control bus between the datapath and the hazard controller.
interface pipeline_hazard_controller_if;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_uses_rs;
    logic        ID_uses_rt;
    logic        ID_mc_start;
    logic [2:0]  ID_mc_cycles;
    logic [4:0]  EX_rs;
    logic [4:0]  EX_rt;
    logic [4:0]  EX_dest;
    logic        EX_rm_write_enable;
    logic        EX_rm_write_data_source;
    logic [4:0]  MEM_dest;
    logic [4:0]  WB_dest;
    logic        MEM_rm_write_enable;
    logic        WB_rm_write_enable;
    logic        branch_taken;
    logic        stat_clear;
    logic        pc_write_enable;
    logic        IF_ID_write_enable;
    logic        IF_ID_flush;
    logic        ID_EX_bubble;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic        busy;
    logic [15:0] stall_count;

    modport master (
        output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_mc_start, ID_mc_cycles,
               EX_rs, EX_rt, EX_dest, EX_rm_write_enable, EX_rm_write_data_source,
               MEM_dest, WB_dest, MEM_rm_write_enable, WB_rm_write_enable,
               branch_taken, stat_clear,
        input  pc_write_enable, IF_ID_write_enable, IF_ID_flush, ID_EX_bubble,
               forward_a, forward_b, busy, stall_count
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_mc_start, ID_mc_cycles,
               EX_rs, EX_rt, EX_dest, EX_rm_write_enable, EX_rm_write_data_source,
               MEM_dest, WB_dest, MEM_rm_write_enable, WB_rm_write_enable,
               branch_taken, stat_clear,
        output pc_write_enable, IF_ID_write_enable, IF_ID_flush, ID_EX_bubble,
               forward_a, forward_b, busy, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Load-use / multi-cycle stall control, branch flush and operand forwarding
// for a 5-stage pipeline, with a saturating stall-cycle counter.
//
// state   | meaning
// RUN     | normal flow; detects load-use hazards and multi-cycle starts
// MC_WAIT | multi-cycle op executing; ID held, mc_cnt counts remaining stalls
// ISSUE   | multi-cycle op done; ID instruction advances (unless load-use)
module pipeline_hazard_controller (
    input  logic                          clock,
    input  logic                          reset,
    pipeline_hazard_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  mc_cnt_q, mc_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic        load_use;
    logic [2:0]  mc_n_m1;
    logic        stall;
    logic        pc_we;

    assign load_use = bus.EX_rm_write_enable && bus.EX_rm_write_data_source &&
                      (bus.EX_dest != 5'd0) &&
                      ((bus.ID_uses_rs && (bus.EX_dest == bus.ID_rs)) ||
                       (bus.ID_uses_rt && (bus.EX_dest == bus.ID_rt)));

    // A zero cycle count is treated as a single-cycle multi-cycle op.
    assign mc_n_m1 = (bus.ID_mc_cycles == 3'd0) ? 3'd0 : (bus.ID_mc_cycles - 3'd1);

    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        stall    = 1'b0;
        if (bus.branch_taken) begin
            state_d  = RUN;
            mc_cnt_d = 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        stall = 1'b1;
                    end else if (bus.ID_mc_start) begin
                        stall = 1'b1;
                        if (mc_n_m1 == 3'd0) begin
                            state_d  = ISSUE;
                            mc_cnt_d = 3'd0;
                        end else begin
                            state_d  = MC_WAIT;
                            mc_cnt_d = mc_n_m1;
                        end
                    end
                end
                MC_WAIT: begin
                    stall    = 1'b1;
                    mc_cnt_d = mc_cnt_q - 3'd1;
                    if (mc_cnt_q == 3'd1) begin
                        state_d  = ISSUE;
                        mc_cnt_d = 3'd0;
                    end
                end
                ISSUE: begin
                    if (load_use) begin
                        stall = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d  = RUN;
                    mc_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // While in reset the pipeline is frozen with a bubble in ID/EX.
    always_comb begin
        bus.pc_write_enable    = 1'b0;
        bus.IF_ID_write_enable = 1'b0;
        bus.IF_ID_flush        = 1'b0;
        bus.ID_EX_bubble       = 1'b1;
        bus.forward_a          = 2'b00;
        bus.forward_b          = 2'b00;
        if (reset) begin
            bus.pc_write_enable    = ~stall;
            bus.IF_ID_write_enable = ~stall;
            bus.IF_ID_flush        = bus.branch_taken;
            bus.ID_EX_bubble       = stall | bus.branch_taken;
            if (bus.MEM_rm_write_enable && (bus.MEM_dest != 5'd0) && (bus.MEM_dest == bus.EX_rs))
                bus.forward_a = 2'b10;
            else if (bus.WB_rm_write_enable && (bus.WB_dest != 5'd0) && (bus.WB_dest == bus.EX_rs))
                bus.forward_a = 2'b01;
            if (bus.MEM_rm_write_enable && (bus.MEM_dest != 5'd0) && (bus.MEM_dest == bus.EX_rt))
                bus.forward_b = 2'b10;
            else if (bus.WB_rm_write_enable && (bus.WB_dest != 5'd0) && (bus.WB_dest == bus.EX_rt))
                bus.forward_b = 2'b01;
        end
    end

    assign pc_we = bus.pc_write_enable;

    always_comb begin
        stall_count_d = stall_count_q;
        if (bus.stat_clear)
            stall_count_d = 16'd0;
        else if (!pc_we && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            mc_cnt_q      <= 3'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            mc_cnt_q      <= mc_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.busy        = (state_q != RUN);
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and randomized checks of pipeline_hazard_controller against a
// cycle-level behavioural model of the stall/forward rules.
module tb_pipeline_hazard_controller;

    logic clock;
    logic reset;
    pipeline_hazard_controller_if bus ();

    pipeline_hazard_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: remaining MC_WAIT cycles, pending issue cycle, stall counter.
    int          m_wait  = 0;
    bit          m_issue = 1'b0;
    logic [15:0] m_cnt   = 16'd0;

    logic obs_stall;
    logic obs_busy;

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (bus.MEM_rm_write_enable && bus.MEM_dest != 0 && bus.MEM_dest == src) return 2'b10;
        if (bus.WB_rm_write_enable && bus.WB_dest != 0 && bus.WB_dest == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        bus.ID_rs = 5'd0; bus.ID_rt = 5'd0; bus.ID_uses_rs = 1'b0; bus.ID_uses_rt = 1'b0;
        bus.ID_mc_start = 1'b0; bus.ID_mc_cycles = 3'd0;
        bus.EX_rs = 5'd0; bus.EX_rt = 5'd0; bus.EX_dest = 5'd0;
        bus.EX_rm_write_enable = 1'b0; bus.EX_rm_write_data_source = 1'b0;
        bus.MEM_dest = 5'd0; bus.WB_dest = 5'd0;
        bus.MEM_rm_write_enable = 1'b0; bus.WB_rm_write_enable = 1'b0;
        bus.branch_taken = 1'b0; bus.stat_clear = 1'b0;
    endtask

    // Called at posedge+1 with inputs set; checks outputs at negedge, then
    // advances the model across the next rising edge.
    task automatic cycle();
        logic hz, stall, e_busy;
        int   nwait, n;
        bit   nissue;
        hz = bus.EX_rm_write_enable && bus.EX_rm_write_data_source && bus.EX_dest != 0 &&
             ((bus.ID_uses_rs && bus.EX_dest == bus.ID_rs) ||
              (bus.ID_uses_rt && bus.EX_dest == bus.ID_rt));
        e_busy = (m_wait > 0) || m_issue;
        stall  = 1'b0;
        nwait  = m_wait;
        nissue = m_issue;
        if (bus.branch_taken) begin
            nwait = 0; nissue = 1'b0;
        end else if (m_wait > 0) begin
            stall = 1'b1; nwait = m_wait - 1; nissue = (nwait == 0);
        end else if (m_issue) begin
            if (hz) stall = 1'b1; else nissue = 1'b0;
        end else if (hz) begin
            stall = 1'b1;
        end else if (bus.ID_mc_start) begin
            stall  = 1'b1;
            n      = (bus.ID_mc_cycles == 0) ? 1 : int'(bus.ID_mc_cycles);
            nwait  = n - 1;
            nissue = (n == 1);
        end
        @(negedge clock);
        chk1("pc_write_enable", bus.pc_write_enable, !stall);
        chk1("IF_ID_write_enable", bus.IF_ID_write_enable, !stall);
        chk1("IF_ID_flush", bus.IF_ID_flush, bus.branch_taken);
        chk1("ID_EX_bubble", bus.ID_EX_bubble, stall || bus.branch_taken);
        chk1("busy", bus.busy, e_busy);
        chk2("forward_a", bus.forward_a, fwd_sel(bus.EX_rs));
        chk2("forward_b", bus.forward_b, fwd_sel(bus.EX_rt));
        chk16("stall_count", bus.stall_count, m_cnt);
        obs_stall = !bus.pc_write_enable;
        obs_busy  = bus.busy;
        @(posedge clock);
        if (bus.stat_clear) m_cnt = 16'd0;
        else if (stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_wait  = nwait;
        m_issue = nissue;
        #1;
    endtask

    task automatic reset_chk(input string tag);
        chk1({tag, "_pc_we"}, bus.pc_write_enable, 1'b0);
        chk1({tag, "_ifid_we"}, bus.IF_ID_write_enable, 1'b0);
        chk1({tag, "_flush"}, bus.IF_ID_flush, 1'b0);
        chk1({tag, "_bubble"}, bus.ID_EX_bubble, 1'b1);
        chk2({tag, "_fwd_a"}, bus.forward_a, 2'b00);
        chk2({tag, "_fwd_b"}, bus.forward_b, 2'b00);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk16({tag, "_stall_count"}, bus.stall_count, 16'd0);
    endtask

    task automatic model_reset();
        m_wait = 0; m_issue = 1'b0; m_cnt = 16'd0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        bus.EX_rm_write_enable = 1'b1; bus.EX_rm_write_data_source = 1'b1;
        bus.EX_dest = r; bus.ID_rs = r; bus.ID_uses_rs = 1'b1;
    endtask

    int s_cnt, b_cnt;

    initial begin
        idle_inputs();
        reset = 1'b0;
        // Forwarding would match if not in reset.
        bus.EX_rs = 5'd2; bus.MEM_dest = 5'd2; bus.MEM_rm_write_enable = 1'b1;
        #2;
        reset_chk("por");
        @(posedge clock); #1;
        reset = 1'b1;
        model_reset();
        idle_inputs();
        cycle();

        // Load-use: single stall cycle.
        set_load_use(5'd5);
        cycle();
        chk1("lu_stall", obs_stall, 1'b1);
        idle_inputs();
        cycle();
        chk1("lu_release", obs_stall, 1'b0);
        chk16("lu_stall_count", bus.stall_count, 16'd1);

        // Multi-cycle N=4: 4 stalls, busy 4 cycles; start held through ISSUE.
        s_cnt = 0; b_cnt = 0;
        bus.ID_mc_start = 1'b1; bus.ID_mc_cycles = 3'd4;
        repeat (5) begin cycle(); s_cnt += int'(obs_stall); b_cnt += int'(obs_busy); end
        chk16("mc4_stalls", 16'(s_cnt), 16'd4);
        chk16("mc4_busy", 16'(b_cnt), 16'd4);
        bus.ID_mc_start = 1'b0;
        cycle();
        chk1("mc4_after", obs_stall, 1'b0);

        for (int nv = 0; nv < 2; nv++) begin
            s_cnt = 0;
            bus.ID_mc_start = 1'b1; bus.ID_mc_cycles = 3'(nv);
            repeat (2) begin cycle(); s_cnt += int'(obs_stall); end
            chk16((nv == 0) ? "mc0_stalls" : "mc1_stalls", 16'(s_cnt), 16'd1);
            bus.ID_mc_start = 1'b0;
            cycle();
        end

        // Branch while MC_WAIT holds mc_cnt = 2.
        bus.ID_mc_start = 1'b1; bus.ID_mc_cycles = 3'd4;
        cycle();
        cycle();
        bus.branch_taken = 1'b1;
        cycle();
        chk1("br_no_stall", obs_stall, 1'b0);
        bus.branch_taken = 1'b0; bus.ID_mc_start = 1'b0;
        cycle();
        chk1("br_run_busy", obs_busy, 1'b0);
        chk1("br_run_stall", obs_stall, 1'b0);

        // Forwarding priority and zero-register suppression.
        bus.EX_rs = 5'd7; bus.EX_rt = 5'd9;
        bus.MEM_dest = 5'd7; bus.WB_dest = 5'd7;
        bus.MEM_rm_write_enable = 1'b1; bus.WB_rm_write_enable = 1'b1;
        cycle();
        chk2("fwd_mem_prio", bus.forward_a, 2'b10);
        bus.MEM_dest = 5'd9;
        cycle();
        bus.MEM_dest = 5'd0; bus.WB_dest = 5'd0; bus.EX_rs = 5'd0;
        cycle();
        chk2("fwd_dest0", bus.forward_a, 2'b00);
        idle_inputs();

        // Randomized traffic over a small register pool to provoke matches.
        repeat (3000) begin
            bus.ID_rs = 5'($urandom_range(0, 3));
            bus.ID_rt = 5'($urandom_range(0, 3));
            bus.ID_uses_rs = 1'($urandom);
            bus.ID_uses_rt = 1'($urandom);
            bus.ID_mc_start = ($urandom_range(0, 7) == 0);
            bus.ID_mc_cycles = 3'($urandom);
            bus.EX_rs = 5'($urandom_range(0, 3));
            bus.EX_rt = 5'($urandom_range(0, 3));
            bus.EX_dest = 5'($urandom_range(0, 3));
            bus.EX_rm_write_enable = 1'($urandom);
            bus.EX_rm_write_data_source = 1'($urandom);
            bus.MEM_dest = 5'($urandom_range(0, 3));
            bus.WB_dest = 5'($urandom_range(0, 3));
            bus.MEM_rm_write_enable = 1'($urandom);
            bus.WB_rm_write_enable = 1'($urandom);
            bus.branch_taken = ($urandom_range(0, 15) == 0);
            bus.stat_clear = ($urandom_range(0, 63) == 0);
            cycle();
        end
        idle_inputs();
        repeat (8) cycle();

        // Saturation under continuous stalls, then clear during a stall.
        set_load_use(5'd3);
        repeat (65540) cycle();
        chk16("sat_hold", bus.stall_count, 16'hFFFF);
        cycle();
        chk16("sat_hold2", bus.stall_count, 16'hFFFF);
        bus.stat_clear = 1'b1;
        cycle();
        chk16("clear_with_stall", bus.stall_count, 16'd0);
        idle_inputs();
        cycle();

        // Asynchronous reset in the middle of MC_WAIT.
        bus.EX_rs = 5'd3; bus.MEM_dest = 5'd3; bus.MEM_rm_write_enable = 1'b1;
        bus.EX_rt = 5'd4; bus.WB_dest = 5'd4; bus.WB_rm_write_enable = 1'b1;
        bus.ID_mc_start = 1'b1; bus.ID_mc_cycles = 3'd5;
        cycle();
        cycle();
        chk1("pre_rst_busy", bus.busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        reset_chk("mid_rst");
        @(posedge clock); #1;
        reset = 1'b1;
        model_reset();
        bus.ID_mc_start = 1'b0;
        cycle();
        chk1("post_rst_stall", obs_stall, 1'b0);
        chk1("post_rst_busy", obs_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
